// File: rtl/display_pkg.sv
// Shared constants for the 4-digit 7-segment scan driver.
// Segment patterns are active-low {dp,g,f,e,d,c,b,a} with dp held off.
package display_pkg;

   localparam int unsigned DIGIT_SEL_W = 2;
   localparam logic [7:0]  SEG_BLANK   = 8'hFF;

   localparam logic [7:0] SEG_DIGIT [10] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
   };

endpackage

// File: rtl/display_seg7_decoder.sv
// Combinational BCD to active-low 7-segment decode; non-decimal codes blank.
module seg7_decoder
   import display_pkg::*;
(
   input  logic [3:0] val_i,
   output logic [7:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      if (val_i < 4'd10)
         seg_o = SEG_DIGIT[val_i];
   end

endmodule

// File: rtl/display.sv
// Time-multiplexed driver for two 0-79 scores on a 4-digit common-anode display.
// Left pair is player 1, right pair is player 2; one digit is lit per prescaler slot.
module display
   import display_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [3:0]             p2_ones,
   input  logic [2:0]             p2_tens,
   input  logic [3:0]             p1_ones,
   input  logic [2:0]             p1_tens,
   output logic [3:0]             an,
   output logic [7:0]             seg,
   output logic [DIGIT_SEL_W-1:0] count
);

   localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

   logic [PW-1:0]          presc_q, presc_d;
   logic [DIGIT_SEL_W-1:0] cnt_q, cnt_d;
   logic [3:0]             an_q, an_d;
   logic [7:0]             seg_q, seg_d;
   logic [3:0]             dig_val;
   logic                   wrap;

   always_comb begin
      wrap    = (presc_q == PRESC_MAX);
      presc_d = wrap ? '0 : presc_q + PW'(1);
      cnt_d   = wrap ? cnt_q + DIGIT_SEL_W'(1) : cnt_q;
   end

   // Select from the live count and live inputs; the output stage adds the one-cycle lag.
   always_comb begin
      an_d    = 4'b1111;
      dig_val = 4'd0;
      case (cnt_q)
         2'd0: begin an_d = 4'b1110; dig_val = p2_ones;         end
         2'd1: begin an_d = 4'b1101; dig_val = {1'b0, p2_tens}; end
         2'd2: begin an_d = 4'b1011; dig_val = p1_ones;         end
         2'd3: begin an_d = 4'b0111; dig_val = {1'b0, p1_tens}; end
         default: ;
      endcase
   end

   seg7_decoder u_dec (
      .val_i (dig_val),
      .seg_o (seg_d)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_q <= '0;
         cnt_q   <= '0;
         an_q    <= 4'b1111;
         seg_q   <= SEG_BLANK;
      end else begin
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

   assign an    = an_q;
   assign seg   = seg_q;
   assign count = cnt_q;

endmodule

// File: tb/tb_display.sv
// Directed-vector bench for display: one instance at REFRESH_DIV=2 for scan
// patterns, one at REFRESH_DIV=8 for mid-slot input change and mid-frame reset.
module tb_display;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] p2_ones, p1_ones;
   logic [2:0] p2_tens, p1_tens;
   logic [3:0] an, an8;
   logic [7:0] seg, seg8;
   logic [1:0] count, count8;

   int n_chk  = 0;
   int n_fail = 0;

   // Expected after the k-th edge following reset release (REFRESH_DIV=2).
   int exp_cnt [9] = '{0, 1, 1, 2, 2, 3, 3, 0, 0};
   int exp_dig [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
   logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   always #5 clk = ~clk;

   display #(.REFRESH_DIV(2)) u_dut (
      .clk, .rst_n, .p2_ones, .p2_tens, .p1_ones, .p1_tens,
      .an(an), .seg(seg), .count(count)
   );

   display #(.REFRESH_DIV(8)) u_dut8 (
      .clk, .rst_n, .p2_ones, .p2_tens, .p1_ones, .p1_tens,
      .an(an8), .seg(seg8), .count(count8)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic edge_s();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Restart the scan and check one full frame plus wrap against four seg patterns.
   task automatic run_frame(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
      logic [7:0] st [4];
      st = '{s0, s1, s2, s3};
      pulse_reset();
      for (int k = 0; k < 9; k++) begin
         edge_s();
         chk($sformatf("%s cnt e%0d", tag, k+1), count, exp_cnt[k]);
         chk($sformatf("%s an e%0d", tag, k+1), an, an_tab[exp_dig[k]]);
         chk($sformatf("%s seg e%0d", tag, k+1), seg, st[exp_dig[k]]);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      p2_ones = 4'd0; p2_tens = 3'd0; p1_ones = 4'd0; p1_tens = 3'd0;
      repeat (3) edge_s();
      chk("rst an", an, 4'b1111);
      chk("rst seg", seg, 8'hFF);
      chk("rst cnt", count, 0);
      chk("rst cnt8", count8, 0);

      run_frame("zero", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

      p1_ones = 4'd5; p2_ones = 4'd5;
      run_frame("fives", 8'h92, 8'hC0, 8'h92, 8'hC0);

      p1_ones = 4'd9; p2_ones = 4'd9; p1_tens = 3'd1; p2_tens = 3'd1;
      run_frame("19s", 8'h90, 8'hF9, 8'h90, 8'hF9);

      p1_ones = 4'd0; p2_ones = 4'd12; p1_tens = 3'd0; p2_tens = 3'd0;
      run_frame("blank", 8'hFF, 8'hC0, 8'hC0, 8'hC0);

      // Tens range top: 7 on both tens digits, 4 and 2 on the ones.
      p1_ones = 4'd4; p2_ones = 4'd2; p1_tens = 3'd7; p2_tens = 3'd7;
      run_frame("tens7", 8'hA4, 8'hF8, 8'h99, 8'hF8);

      // Slow instance: change p2_ones while digit 0 is being shown.
      p1_ones = 4'd0; p1_tens = 3'd0; p2_tens = 3'd0; p2_ones = 4'd3;
      pulse_reset();
      edge_s();
      edge_s();
      chk("d8 an0", an8, 4'b1110);
      chk("d8 seg3", seg8, 8'hB0);
      edge_s();
      p2_ones = 4'd7;
      #2;
      chk("d8 seg hold", seg8, 8'hB0);
      edge_s();
      chk("d8 seg7", seg8, 8'hF8);
      chk("d8 an hold", an8, 4'b1110);
      chk("d8 cnt0", count8, 0);
      repeat (6) edge_s();
      chk("d8 cnt1", count8, 1);
      edge_s();
      chk("d8 an1", an8, 4'b1101);
      chk("d8 seg tens", seg8, 8'hC0);

      // Mid-frame reset on the slow instance.
      rst_n = 1'b0;
      edge_s();
      chk("mid rst an", an8, 4'b1111);
      chk("mid rst seg", seg8, 8'hFF);
      chk("mid rst cnt", count8, 0);
      #1 rst_n = 1'b1;
      edge_s();
      chk("post rst an", an8, 4'b1110);
      chk("post rst seg", seg8, 8'hF8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/display.md
Name: display

Overview:
- Time-multiplexed driver for a 4-digit common-anode 7-segment display showing two air-hockey scores, each 0–79.
- Player 1 occupies the left two digits; player 2 occupies the right two digits.
- Sits between the score counters and the board pins.
- Scans one digit at a time at a rate set by a prescaler. Exposes the current digit index for debug.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz digit rate, 250 Hz frame at 100 MHz); legal range 1..2^20.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- p2_ones  input  4  player-2 ones digit (0–9 valid)
- p2_tens  input  3  player-2 tens digit (0–7)
- p1_ones  input  4  player-1 ones digit (0–9 valid)
- p1_tens  input  3  player-1 tens digit (0–7)
- an  output  4  digit anodes, active-low, one-hot-low while scanning
- seg  output  8  segments, active-low; seg[7]=dp, seg[6:0]={g,f,e,d,c,b,a}
- count  output  2  current digit index

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - prescaler=0, count=0
  - an=4'b1111 (all digits off), seg=8'hFF (all segments off)
- Prescaler:
  - Counts 0..REFRESH_DIV-1.
  - On the cycle it equals REFRESH_DIV-1 it wraps to 0 and count increments (2'b11 wraps to 2'b00).
  - REFRESH_DIV=1 means count increments every cycle.
- Digit mapping, by count:
  - 0: an=1110, p2_ones
  - 1: an=1101, p2_tens
  - 2: an=1011, p1_ones
  - 3: an=0111, p1_tens
- Output registers:
  - an and seg are registered every cycle from the current count and current inputs.
  - Latency: one clk after a change in count or in any score input.
  - Inputs are not latched per frame; a changed score appears on its digit the next time that digit is scanned.
- Decode, active-low, seg[7:0], dp always off (bit7=1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99
  - 5=92, 6=82, 7=F8, 8=80, 9=90
- Ones input values 10–15 display blank (seg=FF); the anode is still driven.
- Tens digits always show their value, including leading 0 (score 5 displays "05").
- count output is the internal counter itself, with no extra latency; an/seg lag it by one cycle.
- Reset asserted mid-scan takes effect at the next edge and restarts at digit 0.
- The prescaler is purely synchronous; no ripple-clock division and no generated clocks.

Decomposition:
- Shared package display_pkg:
  - SEG_BLANK=8'hFF
  - SEG_DIGIT[0:9] constant table
  - DIGIT_SEL_W=2
- Sub-module seg7_decoder: combinational, 4-bit value in, 8-bit active-low pattern out (blank for values above 9). Instantiated once and fed by the count-selected mux.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> an=1111, seg=FF, count=0. Release -> count advances every REFRESH_DIV cycles (run with REFRESH_DIV=2).
- All zero scores, REFRESH_DIV=2 -> (an,seg) cycles 1110/C0, 1101/C0, 1011/C0, 0111/C0; count sequence 0,1,2,3,0.
- p1_ones=5, p2_ones=5, tens 0 -> slot count=0: 1110/92; count=2: 1011/92; tens slots show C0.
- p1_ones=9, p2_ones=9, p1_tens=1, p2_tens=1 -> 1110/90, 1101/F9, 1011/90, 0111/F9.
- p2_ones=12 (invalid) -> digit 0 shows seg=FF with an=1110; other digits unaffected.
- Input change while its digit is active (p2_ones 3→7 during count=0, REFRESH_DIV=8) -> seg goes B0→F8 exactly one clk after the change; reset asserted mid-frame returns to 1111/FF, count=0.
